// File: rtl/io_controller_pkg.sv
// Shared constants for the io_controller: I/O address map, STATUS bit layout, TX FSM states.
package io_controller_pkg;

    localparam int unsigned IO_ADDR_W  = 16;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned LED_W      = 16;
    localparam int unsigned LEDSET_N_W = 9;
    localparam int unsigned ST_W       = 5;

    localparam logic [IO_ADDR_W-1:0] IO_UART_DATA   = 16'h0000;
    localparam logic [IO_ADDR_W-1:0] IO_UART_STATUS = 16'h0002;
    localparam logic [IO_ADDR_W-1:0] IO_LED         = 16'h0004;
    localparam logic [IO_ADDR_W-1:0] IO_LEDSET      = 16'h0006;

    localparam int unsigned ST_TX_FULL     = 0;
    localparam int unsigned ST_RX_NONEMPTY = 1;
    localparam int unsigned ST_TX_IDLE     = 2;
    localparam int unsigned ST_RX_OVERFLOW = 3;
    localparam int unsigned ST_TX_DROP     = 4;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_WAIT_BUSY = 2'd1,
        TX_WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/io_controller_if.sv
// Core I/O port plus UART/LED side signals of the io_controller.
interface io_controller_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 16
);
    logic              io_write_enable;
    logic              io_read_enable;
    logic [ADDR_W-1:0] memory_address;
    logic [WIDTH-1:0]  data_out;
    logic [WIDTH-1:0]  io_data_in;
    logic              uart_wr;
    logic [7:0]        uart_tx_data;
    logic              uart_busy;
    logic              uart_rd;
    logic              uart_valid;
    logic [7:0]        uart_rx_data;
    logic [15:0]       leds;

    // Environment side: core and UART
    modport master (
        output io_write_enable, io_read_enable, memory_address, data_out,
        output uart_busy, uart_valid, uart_rx_data,
        input  io_data_in, uart_wr, uart_tx_data, uart_rd, leds
    );

    // Controller side
    modport slave (
        input  io_write_enable, io_read_enable, memory_address, data_out,
        input  uart_busy, uart_valid, uart_rx_data,
        output io_data_in, uart_wr, uart_tx_data, uart_rd, leds
    );
endinterface

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO, power-of-two depth; push at full and pop at empty are ignored.
module io_sync_fifo #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, rd_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at power-of-two depth
    always_comb begin
        wr_en    = push_i & ~full_o;
        rd_en    = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_en && !rd_en) count_d = count_q + CNT_W'(1);
        if (rd_en && !wr_en) count_d = count_q - CNT_W'(1);
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) mem_q[wr_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/io_controller.sv
// Memory-mapped I/O controller: UART TX/RX buffering and LED register for the j2 core.
module io_controller
    import io_controller_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic           clock,
    input  logic           active_low_reset,
    io_controller_if.slave bus
);
    localparam int unsigned TX_CNT_W = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CNT_W = $clog2(RX_DEPTH) + 1;

    logic                  wr_c, rd_c;
    logic                  sel_data_c, sel_status_c, sel_led_c, sel_ledset_c;
    logic                  tx_push_c, tx_pop_c, rx_push_c, rx_pop_c;
    logic [BYTE_W-1:0]     tx_head, rx_head;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic [TX_CNT_W-1:0]   tx_count;
    logic [RX_CNT_W-1:0]   rx_count;
    logic [ST_W-1:0]       status_c;
    logic [LEDSET_N_W-1:0] ledset_n_c;
    logic [WIDTH-1:0]      rdata_c;
    logic                  unused_data;

    tx_state_e         state_q, state_d;
    logic              wait_q, wait_d;
    logic              uart_wr_q, uart_wr_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              uart_rd_q, uart_rd_d;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              tx_drop_q, tx_drop_d;
    logic              rx_ovf_q, rx_ovf_d;

    // Address decode; a write wins over a simultaneous read
    assign wr_c         = bus.io_write_enable;
    assign rd_c         = bus.io_read_enable & ~bus.io_write_enable;
    assign sel_data_c   = (bus.memory_address == ADDR_W'(IO_UART_DATA));
    assign sel_status_c = (bus.memory_address == ADDR_W'(IO_UART_STATUS));
    assign sel_led_c    = (bus.memory_address == ADDR_W'(IO_LED));
    assign sel_ledset_c = (bus.memory_address == ADDR_W'(IO_LEDSET));
    assign ledset_n_c   = bus.data_out[LEDSET_N_W-1:0];
    assign unused_data  = ^bus.data_out[WIDTH-1:LED_W];

    assign tx_push_c = wr_c & sel_data_c;
    assign rx_pop_c  = rd_c & sel_data_c;
    assign rx_push_c = bus.uart_valid & ~uart_rd_q;

    io_sync_fifo #(.DEPTH(TX_DEPTH), .DATA_W(BYTE_W)) u_tx_fifo (
        .clk     (clock),
        .rst_n   (active_low_reset),
        .push_i  (tx_push_c),
        .pop_i   (tx_pop_c),
        .data_i  (bus.data_out[BYTE_W-1:0]),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    io_sync_fifo #(.DEPTH(RX_DEPTH), .DATA_W(BYTE_W)) u_rx_fifo (
        .clk     (clock),
        .rst_n   (active_low_reset),
        .push_i  (rx_push_c),
        .pop_i   (rx_pop_c),
        .data_i  (bus.uart_rx_data),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // TX scheduler next state, RX drain pulse, LED and sticky flag updates
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        uart_wr_d = 1'b0;
        tx_data_d = tx_data_q;
        tx_pop_c  = 1'b0;
        uart_rd_d = rx_push_c;
        leds_d    = leds_q;
        tx_drop_d = tx_drop_q;
        rx_ovf_d  = rx_ovf_q;

        unique case (state_q)
            TX_IDLE: begin
                if (!tx_empty && !bus.uart_busy) begin
                    uart_wr_d = 1'b1;
                    tx_data_d = tx_head;
                    tx_pop_c  = 1'b1;
                    wait_d    = 1'b0;
                    state_d   = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (bus.uart_busy)   state_d = TX_WAIT_DONE;
                else if (wait_q)     state_d = TX_IDLE;
                else                 wait_d  = 1'b1;
            end
            TX_WAIT_DONE: begin
                if (!bus.uart_busy)  state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase

        if (wr_c && sel_led_c) begin
            leds_d = bus.data_out[LED_W-1:0];
        end else if (wr_c && sel_ledset_c) begin
            if (ledset_n_c == '0)
                leds_d = '0;
            else if (ledset_n_c <= LEDSET_N_W'(LED_W))
                leds_d[4'(ledset_n_c - LEDSET_N_W'(1))] = 1'b1;
        end

        // Clear by write, but a new drop/overflow in the same cycle wins
        if (wr_c && sel_status_c && bus.data_out[ST_TX_DROP])     tx_drop_d = 1'b0;
        if (wr_c && sel_status_c && bus.data_out[ST_RX_OVERFLOW]) rx_ovf_d  = 1'b0;
        if (tx_push_c && tx_full) tx_drop_d = 1'b1;
        if (rx_push_c && rx_full) rx_ovf_d  = 1'b1;
    end

    // Controller state registers
    always_ff @(posedge clock or negedge active_low_reset) begin
        if (!active_low_reset) begin
            state_q   <= TX_IDLE;
            wait_q    <= 1'b0;
            uart_wr_q <= 1'b0;
            tx_data_q <= '0;
            uart_rd_q <= 1'b0;
            leds_q    <= '0;
            tx_drop_q <= 1'b0;
            rx_ovf_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            uart_wr_q <= uart_wr_d;
            tx_data_q <= tx_data_d;
            uart_rd_q <= uart_rd_d;
            leds_q    <= leds_d;
            tx_drop_q <= tx_drop_d;
            rx_ovf_q  <= rx_ovf_d;
        end
    end

    // Combinational read mux; forced to zero while reset is held
    always_comb begin
        status_c                 = '0;
        status_c[ST_TX_FULL]     = tx_full;
        status_c[ST_RX_NONEMPTY] = ~rx_empty;
        status_c[ST_TX_IDLE]     = (tx_count == '0) & (state_q == TX_IDLE) & ~bus.uart_busy;
        status_c[ST_RX_OVERFLOW] = rx_ovf_q;
        status_c[ST_TX_DROP]     = tx_drop_q;

        rdata_c = '0;
        if (sel_data_c && (rx_count != '0)) rdata_c = WIDTH'(rx_head);
        else if (sel_status_c)              rdata_c = WIDTH'(status_c);
        else if (sel_led_c)                 rdata_c = WIDTH'(leds_q);
    end

    assign bus.io_data_in   = active_low_reset ? rdata_c : '0;
    assign bus.uart_wr      = uart_wr_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.uart_rd      = uart_rd_q;
    assign bus.leds         = leds_q;
endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller with UART busy model and TX/RX scoreboards.
module tb_io_controller;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;
    logic busy_model_q = 1'b0;
    logic busy_stuck = 1'b0;
    int   busy_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    localparam logic [15:0] A_DATA   = 16'h0000;
    localparam logic [15:0] A_STATUS = 16'h0002;
    localparam logic [15:0] A_LED    = 16'h0004;
    localparam logic [15:0] A_LEDSET = 16'h0006;

    io_controller_if #(.WIDTH(32), .ADDR_W(16)) bus ();

    io_controller dut (
        .clock            (clk),
        .active_low_reset (rst_n),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    assign bus.uart_busy = busy_model_q | busy_stuck;

    // UART transmitter: busy rises one cycle after uart_wr, held 10 cycles
    always @(posedge clk) begin
        if (bus.uart_wr === 1'b1) begin
            busy_model_q <= 1'b1;
            busy_cnt     <= 10;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) busy_model_q <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX scoreboard and pulse-shape monitors
    always @(negedge clk) begin
        if (bus.uart_wr === 1'b1) begin
            wr_cnt++;
            check("wr_single_cycle", 32'(prev_wr), 32'd0);
            check("wr_busy_low", 32'(bus.uart_busy), 32'd0);
            if (tx_q.size() == 0) check("tx_unexpected_wr", 32'd1, 32'd0);
            else check("tx_byte", 32'(bus.uart_tx_data), 32'(tx_q.pop_front()));
        end
        if (bus.uart_rd === 1'b1) begin
            rd_cnt++;
            check("rd_single_cycle", 32'(prev_rd), 32'd0);
        end
        prev_wr = (bus.uart_wr === 1'b1);
        prev_rd = (bus.uart_rd === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic io_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.memory_address  = a;
        bus.data_out        = d;
        bus.io_write_enable = 1'b1;
        @(negedge clk);
        bus.io_write_enable = 1'b0;
    endtask

    task automatic io_read(input logic [15:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.memory_address = a;
        bus.io_read_enable = 1'b1;
        #1 d = bus.io_data_in;
        @(negedge clk);
        bus.io_read_enable = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] d;
        io_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic rx_send(input logic [7:0] b, input bit accepted);
        bit got = 0;
        if (accepted) rx_q.push_back(b);
        @(negedge clk);
        bus.uart_valid   = 1'b1;
        bus.uart_rx_data = b;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1 if (bus.uart_rd === 1'b1) got = 1;
        end
        bus.uart_valid = 1'b0;
        check("rx_handshake", 32'(got), 32'd1);
    endtask

    task automatic rx_read_expect(input string tag);
        logic [31:0] d;
        io_read(A_DATA, d);
        if (rx_q.size() == 0) check(tag, d, 32'd0);
        else check(tag, d, {24'd0, rx_q.pop_front()});
    endtask

    task automatic wait_tx_idle(input string tag);
        logic [31:0] s;
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            io_read(A_STATUS, s);
            if (s == 32'h4 && tx_q.size() == 0) done = 1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int          base;
        bit          seen;
        logic [31:0] s;

        bus.io_write_enable = 1'b0;
        bus.io_read_enable  = 1'b0;
        bus.memory_address  = A_STATUS;
        bus.data_out        = '0;
        bus.uart_valid      = 1'b0;
        bus.uart_rx_data    = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_wr", 32'(bus.uart_wr), 32'd0);
        check("rst_uart_rd", 32'(bus.uart_rd), 32'd0);
        check("rst_leds", 32'(bus.leds), 32'd0);
        check("rst_io_data_in", bus.io_data_in, 32'd0);
        rst_n = 1'b1;
        read_check("status_after_reset", A_STATUS, 32'h04);

        // Three bytes through the scheduler
        foreach (tx_q[i]) ;
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(8'(8'h41 + i));
            io_write(A_DATA, 32'(8'h41 + i));
        end
        wait_tx_idle("tx3_drain");
        check("tx3_pulses", 32'(wr_cnt), 32'd3);

        // TX overflow with UART stuck busy
        busy_stuck = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back(8'(8'h60 + i));
            io_write(A_DATA, 32'(8'h60 + i));
        end
        check("tx_held_while_busy", 32'(wr_cnt), 32'd3);
        read_check("status_tx_full_drop", A_STATUS, 32'h11);
        io_write(A_STATUS, 32'h10);
        read_check("status_drop_cleared", A_STATUS, 32'h01);
        busy_stuck = 1'b0;
        wait_tx_idle("tx8_drain");
        check("tx8_pulses", 32'(wr_cnt), 32'd11);

        // RX of two bytes, unmapped read does not pop
        base = rd_cnt;
        rx_send(8'h55, 1'b1);
        rx_send(8'hAA, 1'b1);
        check("rx2_pulses", 32'(rd_cnt - base), 32'd2);
        read_check("status_rx_nonempty", A_STATUS, 32'h06);
        read_check("unmapped_read", 16'h0001, 32'd0);
        rx_read_expect("rx_byte0");
        rx_read_expect("rx_byte1");
        read_check("rx_empty_read", A_DATA, 32'd0);
        read_check("status_rx_drained", A_STATUS, 32'h04);

        // RX overflow
        base = rd_cnt;
        for (int i = 0; i < 9; i++) rx_send(8'(8'h80 + i), (i < 8));
        check("rx9_pulses", 32'(rd_cnt - base), 32'd9);
        read_check("status_rx_overflow", A_STATUS, 32'h0E);
        for (int i = 0; i < 8; i++) rx_read_expect("rx_ovf_byte");
        read_check("status_ovf_sticky", A_STATUS, 32'h0C);
        io_write(A_STATUS, 32'h08);
        read_check("status_ovf_cleared", A_STATUS, 32'h04);

        // Simultaneous write and read: write happens, no pop
        rx_send(8'h33, 1'b1);
        tx_q.push_back(8'h07);
        @(negedge clk);
        bus.memory_address  = A_DATA;
        bus.data_out        = 32'h0000_0107;
        bus.io_write_enable = 1'b1;
        bus.io_read_enable  = 1'b1;
        @(negedge clk);
        bus.io_write_enable = 1'b0;
        bus.io_read_enable  = 1'b0;
        io_read(A_STATUS, s);
        check("wr_rd_no_pop", s & 32'h2, 32'h2);
        rx_read_expect("wr_rd_rx_byte");
        wait_tx_idle("wr_rd_tx_drain");

        // LED register and LEDSET
        io_write(A_LED, 32'hFFFF_25A5);
        check("led_write", 32'(bus.leds), 32'h25A5);
        io_write(A_LEDSET, 32'd16);
        check("ledset_16", 32'(bus.leds), 32'hA5A5);
        io_write(A_LEDSET, 32'd2);
        check("ledset_2", 32'(bus.leds), 32'hA5A7);
        io_write(A_LEDSET, 32'd17);
        io_write(A_LEDSET, 32'h110);
        check("ledset_over16", 32'(bus.leds), 32'hA5A7);
        io_write(16'h0008, 32'h0000_0000);
        check("unmapped_write", 32'(bus.leds), 32'hA5A7);
        read_check("led_read", A_LED, 32'hA5A7);
        read_check("ledset_read", A_LEDSET, 32'd0);
        io_write(A_LEDSET, 32'd0);
        check("ledset_0", 32'(bus.leds), 32'h0000);

        // Asynchronous reset during a frame with bytes queued
        io_write(A_LED, 32'hFFFF);
        base = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(8'(8'h91 + i));
            io_write(A_DATA, 32'(8'h91 + i));
        end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1 if (wr_cnt == base + 1) seen = 1;
        end
        check("first_wr_before_reset", 32'(seen), 32'd1);
        bus.memory_address = A_LED;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wr", 32'(bus.uart_wr), 32'd0);
        check("async_rst_rd", 32'(bus.uart_rd), 32'd0);
        check("async_rst_leds", 32'(bus.leds), 32'd0);
        check("async_rst_rdata", bus.io_data_in, 32'd0);
        tx_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("no_wr_after_reset", 32'(wr_cnt), 32'(base + 1));
        read_check("status_after_midreset", A_STATUS, 32'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_controller.md
Name: io_controller

Overview:
- Memory-mapped I/O controller between the j2 core's I/O port and the board peripherals: the buart UART and the 16 LEDs.
- Decodes core I/O reads and writes by address.
- Buffers transmit bytes in a TX FIFO and schedules them into the UART using its busy handshake.
- Drains received bytes from the UART into an RX FIFO and returns read data on io_data_in.

Parameters:
WIDTH, `WIDTH (32), data width of the core's data_out and io_data_in
ADDR_W, 16, width of memory_address
TX_DEPTH, 8, TX FIFO entries (power of two, >=2)
RX_DEPTH, 8, RX FIFO entries (power of two, >=2)

Ports:
clock  in  1  system clock
active_low_reset  in  1  asynchronous, active-low reset
io_write_enable  in  1  core I/O write strobe, one cycle per access
io_read_enable  in  1  core I/O read strobe, one cycle per access
memory_address  in  ADDR_W  I/O address
data_out  in  WIDTH  core write data
io_data_in  out  WIDTH  read data to core
uart_wr  out  1  one-cycle transmit pulse to the UART
uart_tx_data  out  8  byte presented with uart_wr
uart_busy  in  1  UART transmitter busy
uart_rd  out  1  one-cycle receive acknowledge to the UART
uart_valid  in  1  UART holds a received byte
uart_rx_data  in  8  received byte
leds  out  16  LED outputs; leds[0] drives led01

Behaviour:
- Reset is asynchronous, active-low. On reset, every register clears: FIFOs empty, FSM in IDLE, leds=0, uart_wr=0, uart_rd=0, sticky flags=0. io_data_in=0 while reset is asserted.
- Address map (decode is exact; any other address reads 0 and ignores writes):
  0x0000 DATA. Write pushes data_out[7:0] into the TX FIFO. Read returns {0, rx_head[7:0]} and pops the RX FIFO.
  0x0002 STATUS (read): bit0 tx_full, bit1 rx_nonempty, bit2 tx_idle (TX FIFO empty & FSM IDLE & !uart_busy), bit3 rx_overflow, bit4 tx_drop; all other bits 0. A write with data_out[3]=1 clears rx_overflow; a write with data_out[4]=1 clears tx_drop.
  0x0004 LED. Write sets leds<=data_out[15:0]. Read returns {0, leds}.
  0x0006 LEDSET. Write with data_out[8:0]=n, 1<=n<=16, sets leds[n-1]<=1; n=0 clears all leds; n>16 is ignored. Read returns 0.
- io_data_in is combinational from memory_address and current state. A pop takes effect on the clock edge ending the read-strobe cycle. RX pop when empty returns 0 and changes nothing.
- A TX push when the FIFO is full drops the byte and sets tx_drop. This holds even if the scheduler pops in the same cycle.
- Simultaneous io_write_enable and io_read_enable: the write is performed and the read is ignored (no pop).
- TX scheduler FSM:
  IDLE: if TX FIFO nonempty and !uart_busy, drive uart_wr=1 for one cycle with uart_tx_data=head, pop, go to WAIT_BUSY.
  WAIT_BUSY: if uart_busy=1, go to WAIT_DONE. If busy is not seen within 2 cycles, go to IDLE (guard against a missed handshake).
  WAIT_DONE: when uart_busy=0, go to IDLE.
  Throughput: at most one byte per UART frame. uart_tx_data holds its value until the next uart_wr.
- RX drain:
  When uart_valid=1 and no uart_rd was issued in the previous cycle, drive uart_rd=1 for one cycle and push uart_rx_data into the RX FIFO in the same edge.
  If the RX FIFO is full, the byte is dropped, rx_overflow is set, and uart_rd is still pulsed to clear the UART.
  An RX push and a core pop in the same cycle are both performed (count unchanged), except at full, where the push is dropped.
- FIFO pointers wrap modulo depth. Count is ADDR-independent and spans 0..DEPTH inclusive.
- Reset mid-frame: the FSM returns to IDLE and queued bytes are lost. The UART frame in flight is not this block's concern.

Decomposition:
- Shared package: I/O address constants (IO_UART_DATA, IO_UART_STATUS, IO_LED, IO_LEDSET), STATUS bit indices, and TX FSM state encoding (IDLE, WAIT_BUSY, WAIT_DONE).
- One sub-module, io_sync_fifo (parameters DEPTH, DATA_W=8). It has push, pop, full, empty, head outputs and count, and is instantiated twice (TX and RX).

Test Plan:
- Reset, then write 0x41, 0x42, 0x43 to 0x0000 with a uart_busy model (busy 1 cycle after wr, held 10 cycles) -> three uart_wr pulses, data 0x41, 0x42, 0x43 in order, each after busy falls. STATUS bit2 returns to 1 at the end.
- With busy stuck high, write 9 bytes to 0x0000 -> first 8 are accepted, the 9th is dropped. STATUS reads 0x11 (tx_full, tx_drop). Writing 0x10 to 0x0002 clears bit4.
- Present uart_valid with bytes 0x55 then 0xAA -> two single-cycle uart_rd pulses. STATUS bit1=1. Reads of 0x0000 return 0x55 then 0xAA, then 0 with the FIFO empty.
- Inject 9 RX bytes without reading -> rx_overflow set (STATUS bit3=1). Reads return the first 8 bytes in order.
- LED: write 0x0000A5A5 to 0x0004 -> leds=0xA5A5. LEDSET n=16 -> leds[15]=1. n=0 -> leds=0. n=17 -> leds unchanged.
- Assert active_low_reset asynchronously mid-transmit with 3 bytes queued -> all outputs 0 immediately. After release, no uart_wr occurs and STATUS reads 0x04.
